// File: rtl/processor_pkg.sv
// Shared core package: instruction/address width and the fetch-queue entry type.
package processor_pkg;

  localparam int WORD_SIZE = 16;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
  } fetch_entry_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetch entries for the instruction prefetch queue.
// Pointers wrap naturally at DEPTH (power of two). Clear empties the buffer
// in one cycle; the caller guarantees no push when full and no pop when empty.
module prefetch_fifo
  import processor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge Clock) begin
    if (push && !clear) storage[tail_ptr] <= push_data;
  end

  assign head = storage[head_ptr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues instruction-memory reads ahead of Fetch,
// buffers returned words with their PCs, and redirects on Flush while
// discarding stale queued and in-flight words.
// Build option: INSTR_PREFETCH_BYPASS_EN presents a kept response directly on
// the Instr* outputs in its arrival cycle when the queue is empty.
module instr_prefetch_queue #(
  parameter int WORD_SIZE = processor_pkg::WORD_SIZE,
  parameter int DEPTH     = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Flush,
  input  logic [WORD_SIZE-1:0] FlushAddr,
  input  logic                 Consume,
  output logic [WORD_SIZE-1:0] InstrOut,
  output logic [WORD_SIZE-1:0] InstrPC,
  output logic                 InstrValid,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic                 MemRead,
  input  logic                 MemWaitreq,
  input  logic [WORD_SIZE-1:0] MemData,
  input  logic                 MemDataValid
);

  import processor_pkg::*;

  localparam int            CW      = occ_width(DEPTH);
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];

  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] resp_pc;
  logic [WORD_SIZE-1:0] held_addr;
  logic [CW-1:0]        pending;
  logic [CW-1:0]        pending_next;
  logic [CW-1:0]        drop;
  logic [CW-1:0]        drop_next;
  logic [CW-1:0]        count;
  logic [CW:0]          in_flight;
  logic                 held;
  logic                 held_stale;
  logic                 accept;
  logic                 fresh;
  logic                 keep;
  logic                 push;
  logic                 pop;
  logic                 fifo_valid;
  logic                 bypass;
  fetch_entry_t         push_data;
  fetch_entry_t         head;

  // A held request keeps MemRead/MemAddr stable even across a Flush; fresh
  // requests need Flush low and a free credit (queued + outstanding < DEPTH).
  assign in_flight = {1'b0, count} + {1'b0, pending};
  assign MemRead   = !Reset && (held || (!Flush && (in_flight < DEPTH_W)));
  assign MemAddr   = held ? held_addr : fetch_pc;
  assign accept    = MemRead && !MemWaitreq;
  // fetch_pc advances when an address is first presented, so a held request
  // keeps its own copy in held_addr and a Flush can retarget fetch_pc freely.
  assign fresh     = MemRead && !held;
  assign keep      = MemDataValid && (drop == '0);
  assign fifo_valid = (count != '0);

`ifdef INSTR_PREFETCH_BYPASS_EN
  assign bypass = !Reset && keep && !Flush && !fifo_valid;
  assign push   = keep && !Flush && !(bypass && Consume);
`else
  assign bypass = 1'b0;
  assign push   = keep && !Flush;
`endif

  assign pop        = fifo_valid && Consume && !Flush;
  assign InstrValid = fifo_valid || bypass;
  assign InstrOut   = fifo_valid ? head.instr : (bypass ? MemData : '0);
  assign InstrPC    = fifo_valid ? head.pc    : (bypass ? resp_pc : '0);

  assign push_data.instr = MemData;
  assign push_data.pc    = resp_pc;

  // Outstanding-read and discard counter updates for a non-flush cycle.
  always_comb begin
    pending_next = pending;
    if (accept && !MemDataValid)      pending_next = pending + 1'b1;
    else if (!accept && MemDataValid) pending_next = pending - 1'b1;
    drop_next = drop;
    if (MemDataValid && (drop != '0)) drop_next = drop - 1'b1;
    // A request held across a Flush is stale once memory finally takes it.
    if (accept && held_stale)         drop_next = drop_next + 1'b1;
  end

  // PC, credit and waitreq-hold state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_pc   <= '0;
      resp_pc    <= '0;
      held_addr  <= '0;
      pending    <= '0;
      drop       <= '0;
      held       <= 1'b0;
      held_stale <= 1'b0;
    end else begin
      held       <= MemRead && MemWaitreq;
      held_addr  <= MemAddr;
      held_stale <= MemRead && MemWaitreq && (Flush || held_stale);
      pending    <= pending_next;
      if (Flush) begin
        fetch_pc <= FlushAddr;
        resp_pc  <= FlushAddr;
        // Everything still outstanding after this cycle belongs to the old path.
        drop     <= pending_next;
      end else begin
        if (fresh) fetch_pc <= fetch_pc + 1'b1;
        if (keep)  resp_pc  <= resp_pc + 1'b1;
        drop <= drop_next;
      end
    end
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (Flush),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch unit sitting directly upstream of the processor's Fetch stage. It drives instruction-memory reads ahead of demand, buffers returned words with their PCs in a small circular queue, and presents them to Fetch through a valid/consume handshake. A Flush from the pipeline redirects fetching to a new PC and discards stale queued and in-flight words.

## Interface
Parameters:
- WORD_SIZE, 16, instruction and address width.
- DEPTH, 4, queue entries and maximum accepted-but-unreturned reads; power of two, at least 2.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Flush  in  1  redirect request from the pipeline (branch taken or exception).
- FlushAddr  in  WORD_SIZE  new fetch PC, sampled when Flush=1.
- Consume  in  1  Fetch takes the head entry this cycle.
- InstrOut  out  WORD_SIZE  head instruction word.
- InstrPC  out  WORD_SIZE  PC of the head instruction.
- InstrValid  out  1  head entry valid.
- MemAddr  out  WORD_SIZE  instruction-memory word address.
- MemRead  out  1  read request.
- MemWaitreq  in  1  memory stalls the current request.
- MemData  in  WORD_SIZE  read data.
- MemDataValid  in  1  MemData valid; responses return in order, latency ≥ 1 cycle.

## Operation
- Internal state: fetch_pc (next address to request), resp_pc (PC of next kept response), count (queued entries), pending (accepted reads not yet returned), drop (pending reads to discard).
- Issue: MemRead=1 whenever a request is held under waitreq, or when Flush=0 and count+pending < DEPTH. MemAddr=fetch_pc.
- Accept: MemRead && !MemWaitreq. fetch_pc += 1 (modulo 2^WORD_SIZE), pending += 1.
- Waitreq: while MemRead && MemWaitreq, MemRead and MemAddr hold unchanged, including across a Flush.
- Response: on MemDataValid, pending -= 1. If drop>0, drop -= 1 and the word is discarded. Otherwise {MemData, resp_pc} is pushed and resp_pc += 1.
- Pop: InstrValid && Consume removes the head. Consume while InstrValid=0 is ignored.
- Simultaneous push and pop: both take effect; count is unchanged. The credit rule makes overflow impossible.
- Flush has priority over Consume and push:
  - The queue is cleared.
  - fetch_pc and resp_pc load FlushAddr.
  - drop loads the number of reads still outstanding after this cycle, counting a held request accepted in this cycle and excluding a response returning in this cycle.
  - If a request is held under waitreq, it completes at its old address, is counted into drop, and the next request uses FlushAddr.
- No state machine beyond the counters. The queue is a circular buffer with head/tail pointers that wrap at DEPTH.

## Timing
- Reset values: InstrValid=0, InstrOut=0, InstrPC=0, MemRead=0, MemAddr=0; all counters 0, fetch_pc=resp_pc=0.
- Reset mid-operation discards everything. The memory must also be reset, because responses arriving after Reset are not dropped.
- First request is issued the cycle after Reset deasserts.
- Response to visible head: MemDataValid in cycle t gives InstrValid in cycle t+1 (without bypass).
- Redirect: Flush in cycle 0 → MemRead with MemAddr=FlushAddr in cycle 1, when there is no held request.
- Sustained throughput is one instruction per cycle when memory latency ≤ DEPTH−1 and waitreq is never asserted.

## Configuration
- INSTR_PREFETCH_BYPASS_EN defined: when the queue is empty (or being flushed-free) and a kept response arrives, InstrOut/InstrPC/InstrValid present it combinationally in the same cycle. If Consume=1 in that cycle, the word is not enqueued.
- Undefined: all outputs are registered from queue storage. Latency is one cycle longer.

## Structure
- Shared package processor_pkg holds WORD_SIZE and the typedef fetch_entry_t {instr, pc}. The processor core imports the same package.
- Sub-module prefetch_fifo: a DEPTH-entry circular buffer of fetch_entry_t with push, pop, clear, count and head outputs. The top level owns the PC, pending and drop counters and the memory handshake.

## Test plan
- Reset, memory with 1-cycle latency and no waitreq, Consume=1 → MemAddr 0,1,2,…; InstrPC 0,1,2,… one per cycle from cycle 3; InstrOut matches memory contents.
- Consume=0 → exactly DEPTH=4 reads accepted, then MemRead=0; count=4; first Consume pop restarts requests at address 4.
- MemWaitreq=1 for 3 cycles on address 2 → MemAddr stays 2 and MemRead stays 1; no duplicate or skipped PCs.
- 3-cycle latency, Flush with FlushAddr=0x40 while 2 reads are pending → both stale words discarded; next InstrPC=0x40 with the word at 0x40.
- Flush during waitreq on address 5 → address 5 completes and is dropped; next MemAddr=FlushAddr; no stale InstrValid.
- Flush and Consume in the same cycle with the queue full → queue empty next cycle, InstrValid=0.
